ahb_to_ssram_bridge: RTL and testbench

AHB-Lite slave that maps single AHB transfers onto a single-port synchronous SRAM built from four byte-wide banks. It sits between the AHB interconnect (or a bus driver in simulation) and four 8-bit sync RAMs with one-cycle read latency. Writes are posted: address is captured in the address phase and the SRAM write happens in the data phase. Reads are zero-wait except when they collide with a pending write.

---
 rtl/ahb_to_ssram_bridge.sv | 206 ++++++++++++++++++++
 tb/tb_ahb_to_ssram_bridge.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_to_ssram_bridge.sv
`timescale 1ns/1ps
// ahb_to_ssram_bridge
//
// AHB-Lite slave in front of a single-port synchronous SRAM that is built
// from four byte-wide banks with one-cycle read latency.
//
// Writes are posted. The address and byte-lane mask are captured in the
// address phase, and the SRAM write is issued in the data phase, when HWDATA
// is valid. A read normally goes straight to the SRAM in its address phase,
// so it completes with no wait states.
//
// A read whose address phase coincides with a write data phase cannot use the
// single SRAM port. In that case the read address is parked, and the read
// data phase stretches by one wait cycle.
//
// Optional feature (compile-time macro AHB_SSRAM_ERR_EN):
//   When the macro is defined, the following transfers get the two-cycle
//   ERROR response and never touch the SRAM:
//     - HSIZE > 2;
//     - a halfword transfer that is not halfword-aligned;
//     - a word transfer that is not word-aligned.
//   When the macro is not defined, HRESP is always OKAY, HSIZE > 2 behaves
//   as a word transfer, and misaligned addresses are simply masked.
//
// Ports
//   HCLK, HRESET            clock (rising edge) and synchronous active-high reset
//   HSEL, HADDR, HTRANS,
//   HSIZE, HWRITE, HWDATA,
//   HREADY                  AHB-Lite slave inputs
//   HREADYOUT, HRDATA,
//   HRESP                   AHB-Lite slave outputs
//   ahb_sram_addr           SRAM word address
//   ahb_sram_enb/_wb        per-lane enable / write enable
//   ahb_sram_en/_we         OR of the per-lane enables
//   ahb_sram_din            SRAM write data (HWDATA)
//   sram_ahb_dout           SRAM read data, valid one cycle after a read enable
module ahb_to_ssram_bridge #(
    parameter int AW = 12
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic          HSEL,
    input  logic [AW-1:0] HADDR,
    input  logic [1:0]    HTRANS,
    input  logic [2:0]    HSIZE,
    input  logic          HWRITE,
    input  logic [31:0]   HWDATA,
    input  logic          HREADY,
    output logic          HREADYOUT,
    output logic [31:0]   HRDATA,
    output logic          HRESP,
    output logic [AW-1:0] ahb_sram_addr,
    output logic [3:0]    ahb_sram_enb,
    output logic [3:0]    ahb_sram_wb,
    output logic          ahb_sram_en,
    output logic          ahb_sram_we,
    output logic [31:0]   ahb_sram_din,
    input  logic [31:0]   sram_ahb_dout
);

    typedef enum logic [2:0] {
        ST_IDLE,     // no data phase in progress
        ST_WR,       // write data phase: SRAM write this cycle
        ST_RD,       // zero-wait read data phase completing
        ST_RD_WAIT,  // collided read, SRAM read from parked address
        ST_RD_LAST,  // collided read completing
        ST_ERR1,     // first ERROR cycle
        ST_ERR2      // second ERROR cycle
    } state_t;

    state_t          state_reg;
    logic            hreadyout_reg;
    logic            hresp_reg;
    logic [AW-1:0]   wr_addr_reg;
    logic [3:0]      wr_mask_reg;
    logic [AW-1:0]   rd_addr_reg;

    logic            xfer_accept;
    logic            xfer_err;
    logic [AW-1:0]   word_addr;
    logic [3:0]      lane_mask;
    logic            size_byte;
    logic            size_half;
    logic            size_word;
    logic [AW-1:0]   sram_addr_next;
    logic [3:0]      sram_enb_next;
    logic [3:0]      sram_wb_next;

    // HTRANS[0] only separates NONSEQ from SEQ, which this slave treats alike.
    logic            unused_bits;
    assign unused_bits = &{1'b0, HTRANS[0]};

    assign xfer_accept = HSEL & HREADY & HTRANS[1];
    assign word_addr   = {2'b00, HADDR[AW-1:2]};

    assign size_byte = (HSIZE == 3'd0);
    assign size_half = (HSIZE == 3'd1);
    assign size_word = (HSIZE >= 3'd2);

    // Byte-lane mask. A word (or any oversize) access covers all four lanes.
    // A halfword access covers the upper or lower pair. A byte access covers
    // the single addressed lane.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign lane_mask[gi] = size_word
                                 | (size_half & (HADDR[1] == LANE[1]))
                                 | (size_byte & (HADDR[1:0] == LANE));
        end
    endgenerate

`ifdef AHB_SSRAM_ERR_EN
    assign xfer_err = (HSIZE > 3'd2)
                    | (size_half & HADDR[0])
                    | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00));
`else
    assign xfer_err = 1'b0;
`endif

    // Transfer sequencing.
    // ST_RD_WAIT and ST_ERR1 drive HREADYOUT low, so the bus cannot present a
    // new address phase in those states. Those states therefore advance
    // unconditionally.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_reg     <= ST_IDLE;
            hreadyout_reg <= 1'b1;
            hresp_reg     <= 1'b0;
            wr_addr_reg   <= '0;
            wr_mask_reg   <= '0;
            rd_addr_reg   <= '0;
        end else begin
            case (state_reg)
                ST_RD_WAIT: begin
                    state_reg     <= ST_RD_LAST;
                    hreadyout_reg <= 1'b1;
                end
                ST_ERR1: begin
                    state_reg     <= ST_ERR2;
                    hreadyout_reg <= 1'b1;
                    hresp_reg     <= 1'b1;
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    hreadyout_reg <= 1'b1;
                    hresp_reg     <= 1'b0;
                    if (xfer_accept) begin
                        if (xfer_err) begin
                            state_reg     <= ST_ERR1;
                            hreadyout_reg <= 1'b0;
                            hresp_reg     <= 1'b1;
                        end else if (HWRITE) begin
                            state_reg   <= ST_WR;
                            wr_addr_reg <= word_addr;
                            wr_mask_reg <= lane_mask;
                        end else if (state_reg == ST_WR) begin
                            // The SRAM port is busy with the posted write,
                            // so the read address is parked for one cycle.
                            state_reg     <= ST_RD_WAIT;
                            hreadyout_reg <= 1'b0;
                            rd_addr_reg   <= word_addr;
                        end else begin
                            state_reg <= ST_RD;
                        end
                    end
                end
            endcase
        end
    end

    // SRAM port arbitration. A posted write has priority over everything
    // else, then a parked read, then a fresh read in its address phase.
    // Holding reset blocks every access, so a write that is in flight when
    // reset arrives is dropped.
    always_comb begin
        sram_addr_next = word_addr;
        sram_enb_next  = 4'b0000;
        sram_wb_next   = 4'b0000;
        if (!HRESET) begin
            if (state_reg == ST_WR) begin
                sram_addr_next = wr_addr_reg;
                sram_enb_next  = wr_mask_reg;
                sram_wb_next   = wr_mask_reg;
            end else if (state_reg == ST_RD_WAIT) begin
                sram_addr_next = rd_addr_reg;
                sram_enb_next  = 4'b1111;
            end else if (xfer_accept && !HWRITE && !xfer_err) begin
                sram_enb_next  = 4'b1111;
            end
        end
    end

    assign ahb_sram_addr = sram_addr_next;
    assign ahb_sram_enb  = sram_enb_next;
    assign ahb_sram_wb   = sram_wb_next;
    assign ahb_sram_en   = |sram_enb_next;
    assign ahb_sram_we   = |sram_wb_next;
    assign ahb_sram_din  = HWDATA;

    assign HREADYOUT = hreadyout_reg;
    assign HRESP     = hresp_reg;
    assign HRDATA    = ((state_reg == ST_RD) || (state_reg == ST_RD_LAST))
                       ? sram_ahb_dout : 32'h0;

endmodule

// File: tb/tb_ahb_to_ssram_bridge.sv
`timescale 1ns/1ps
// Testbench for ahb_to_ssram_bridge: pipelined AHB driver, byte-bank SRAM
// model, and a byte-addressed reference memory for expected read data.
module tb_ahb_to_ssram_bridge;
    localparam int AW = 12;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic          HSEL;
    logic [AW-1:0] HADDR;
    logic [1:0]    HTRANS;
    logic [2:0]    HSIZE;
    logic          HWRITE;
    logic [31:0]   HWDATA;
    logic          HREADY;
    logic          HREADYOUT;
    logic [31:0]   HRDATA;
    logic          HRESP;
    logic [AW-1:0] ahb_sram_addr;
    logic [3:0]    ahb_sram_enb;
    logic [3:0]    ahb_sram_wb;
    logic          ahb_sram_en;
    logic          ahb_sram_we;
    logic [31:0]   ahb_sram_din;
    logic [31:0]   sram_ahb_dout;

    always #5 HCLK = ~HCLK;
    assign HREADY = HREADYOUT;

    ahb_to_ssram_bridge #(.AW(AW)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA),
        .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP),
        .ahb_sram_addr(ahb_sram_addr), .ahb_sram_enb(ahb_sram_enb),
        .ahb_sram_wb(ahb_sram_wb), .ahb_sram_en(ahb_sram_en),
        .ahb_sram_we(ahb_sram_we), .ahb_sram_din(ahb_sram_din),
        .sram_ahb_dout(sram_ahb_dout)
    );

    // Four byte-wide synchronous RAMs, read-first, one-cycle read latency.
    logic [7:0] sram_mem [0:3][0:4095];
    always @(posedge HCLK) begin
        for (int i = 0; i < 4; i++) begin
            if (ahb_sram_enb[i]) begin
                if (ahb_sram_wb[i]) sram_mem[i][ahb_sram_addr] <= ahb_sram_din[8*i +: 8];
                sram_ahb_dout[8*i +: 8] <= sram_mem[i][ahb_sram_addr];
            end
        end
    end

    typedef struct {
        logic        wr;
        logic        idle;
        logic [11:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } xfer_t;

    xfer_t       xq[$];
    logic [7:0]  ref_mem [0:4095];
    logic [31:0] last_rd;
    int          last_waits;
    int          total = 0;
    int          bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // Reference model: an access covers 1, 2 or 4 bytes starting at the
    // address rounded down to the access size; oversize counts as 4 bytes.
    function automatic int ref_nbytes(input logic [2:0] s);
        return (s >= 3'd2) ? 4 : (1 << s);
    endfunction

    function automatic logic [3:0] ref_mask(input logic [11:0] a, input logic [2:0] s);
        int n;
        int start;
        logic [3:0] m;
        n = ref_nbytes(s);
        start = int'(a) & ~(n - 1);
        m = 4'b0000;
        for (int j = 0; j < n; j++) m[(start + j) % 4] = 1'b1;
        return m;
    endfunction

    task automatic ref_write(input logic [11:0] a, input logic [2:0] s, input logic [31:0] d);
        int n;
        int start;
        n = ref_nbytes(s);
        start = int'(a) & ~(n - 1);
        for (int j = 0; j < n; j++) ref_mem[start + j] = d[8*((start + j) % 4) +: 8];
    endtask

    function automatic logic [31:0] ref_word(input logic [11:0] a);
        int b;
        b = int'(a) & ~3;
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    task automatic push(input logic wr, input logic [11:0] a, input logic [2:0] s,
                        input logic [31:0] d, input logic idle);
        xfer_t x;
        x.wr = wr; x.idle = idle; x.addr = a; x.size = s; x.wdata = d;
        xq.push_back(x);
    endtask

    // Pipelined master: one address phase overlaps the previous data phase.
    // Inputs change on the falling edge; outputs are checked 1 ns later.
    task automatic run_queue();
        xfer_t ap;
        xfer_t dp;
        logic  ap_v, dp_v, dp_wait_exp;
        logic  wr_dp, rd_wait, rd_ap;
        logic [3:0] exp_mask;
        int    waits, guard;
        ap.wr = 0; ap.idle = 1; ap.addr = 0; ap.size = 0; ap.wdata = 0;
        dp = ap;
        ap_v = 0; dp_v = 0; dp_wait_exp = 0; waits = 0; guard = 0;
        if (xq.size() > 0) begin ap = xq.pop_front(); ap_v = 1; end
        while ((ap_v || dp_v) && guard < 4000) begin
            @(negedge HCLK);
            guard++;
            if (ap_v && !ap.idle) begin
                HSEL = 1'b1; HTRANS = 2'b10; HWRITE = ap.wr; HADDR = ap.addr; HSIZE = ap.size;
            end else begin
                HSEL   = 1'($urandom_range(0, 1));
                HTRANS = {1'b0, 1'($urandom_range(0, 1))};
                HWRITE = 1'($urandom_range(0, 1));
                HADDR  = 12'($urandom);
                HSIZE  = 3'($urandom_range(0, 2));
            end
            HWDATA = (dp_v && dp.wr) ? dp.wdata : $urandom;
            #1;
            wr_dp   = dp_v && dp.wr;
            rd_wait = dp_v && !dp.wr && !HREADYOUT;
            rd_ap   = ap_v && !ap.idle && !ap.wr;
            if (wr_dp) begin
                exp_mask = ref_mask(dp.addr, dp.size);
                check("wr_ready", HREADYOUT, 1);
                check("wr_addr", ahb_sram_addr, dp.addr >> 2);
                check("wr_wb", ahb_sram_wb, exp_mask);
                check("wr_enb", ahb_sram_enb, exp_mask);
                check("wr_en_we", {ahb_sram_en, ahb_sram_we}, 2'b11);
                check("wr_din", ahb_sram_din, dp.wdata);
                check("wr_rdata", HRDATA, 0);
                ref_write(dp.addr, dp.size, dp.wdata);
            end else if (rd_wait) begin
                waits++;
                check("rdw_enb", ahb_sram_enb, 4'hF);
                check("rdw_wb", ahb_sram_wb, 0);
                check("rdw_addr", ahb_sram_addr, dp.addr >> 2);
                check("rdw_rdata", HRDATA, 0);
                if (waits > 3) begin
                    check("rd_wait_bound", waits, 1);
                    break;
                end
            end else if (dp_v) begin
                check("rd_data", HRDATA, ref_word(dp.addr));
                check("rd_waits", waits, dp_wait_exp);
                last_rd = HRDATA;
                last_waits = waits;
            end else begin
                check("idle_ready", HREADYOUT, 1);
                check("idle_rdata", HRDATA, 0);
            end
            check("resp_okay", HRESP, 0);
            if (!wr_dp && !rd_wait) begin
                if (rd_ap) begin
                    check("rda_enb", {ahb_sram_en, ahb_sram_we, ahb_sram_enb, ahb_sram_wb}, 10'b10_1111_0000);
                    check("rda_addr", ahb_sram_addr, ap.addr >> 2);
                end else begin
                    check("no_access", {ahb_sram_en, ahb_sram_we, ahb_sram_enb, ahb_sram_wb}, 0);
                end
            end
            if (HREADYOUT) begin
                if (ap_v && !ap.idle) begin
                    dp_wait_exp = dp_v && dp.wr && !ap.wr;
                    dp = ap;
                    dp_v = 1;
                end else begin
                    dp_v = 0;
                end
                waits = 0;
                ap_v = 0;
                if (xq.size() > 0) begin ap = xq.pop_front(); ap_v = 1; end
            end
        end
        if (guard >= 4000) check("queue_guard", guard, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        xfer_t x;
        HRESET = 1'b1; HSEL = 0; HADDR = 0; HTRANS = 0; HSIZE = 0; HWRITE = 0; HWDATA = 0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
        last_rd = 0; last_waits = 0;

        // Reset held three cycles.
        repeat (3) @(negedge HCLK);
        HRESET = 1'b0;
        #1;
        check("rst_ready", HREADYOUT, 1);
        check("rst_resp", HRESP, 0);
        check("rst_rdata", HRDATA, 0);
        check("rst_en", {ahb_sram_en, ahb_sram_we, ahb_sram_enb, ahb_sram_wb}, 0);

        // Give the low memory region known contents.
        for (int i = 0; i < 16; i++) push(1, 12'(i * 4), 3'd2, $urandom, 0);
        run_queue();

        // Word writes separated by an idle cycle.
        push(1, 12'h010, 3'd2, 32'hCAFEBABE, 0);
        push(0, 12'h000, 3'd0, 32'h0, 1);
        push(1, 12'h014, 3'd2, 32'h12345678, 0);
        run_queue();

        // Plain read after idles.
        push(0, 12'h000, 3'd0, 32'h0, 1);
        push(0, 12'h000, 3'd0, 32'h0, 1);
        push(0, 12'h010, 3'd2, 32'h0, 0);
        run_queue();
        check("dir_rd_cafe", last_rd, 32'hCAFEBABE);
        check("dir_rd_cafe_waits", last_waits, 0);

        // Byte write followed immediately by a colliding read.
        push(1, 12'h013, 3'd0, 32'hAA000000, 0);
        push(0, 12'h010, 3'd2, 32'h0, 0);
        run_queue();
        check("dir_byte_coll", last_rd, 32'hAAFEBABE);
        check("dir_byte_waits", last_waits, 1);

        // Halfword write followed by a colliding read.
        push(1, 12'h016, 3'd1, 32'h55550000, 0);
        push(0, 12'h014, 3'd2, 32'h0, 0);
        run_queue();
        check("dir_half_coll", last_rd, 32'h55555678);
        check("dir_half_waits", last_waits, 1);

`ifdef AHB_SSRAM_ERR_EN
        // Misaligned word write gets ERROR and leaves memory alone.
        @(negedge HCLK);
        HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HSIZE = 3'd2; HADDR = 12'h011; HWDATA = $urandom;
        #1;
        check("err_aph_en", {ahb_sram_en, ahb_sram_we}, 0);
        @(negedge HCLK);
        HSEL = 0; HTRANS = 2'b00; HWDATA = 32'hFFFFFFFF;
        #1;
        check("err1_ready", HREADYOUT, 0);
        check("err1_resp", HRESP, 1);
        check("err1_en", {ahb_sram_en, ahb_sram_we}, 0);
        @(negedge HCLK);
        #1;
        check("err2_ready", HREADYOUT, 1);
        check("err2_resp", HRESP, 1);
        check("err2_en", {ahb_sram_en, ahb_sram_we}, 0);
        @(negedge HCLK);
        #1;
        check("err_done_resp", HRESP, 0);
        push(0, 12'h010, 3'd2, 32'h0, 0);
        run_queue();
        check("err_mem_kept", last_rd, 32'hAAFEBABE);
`endif

        // Reset during a write data phase drops the write.
        @(negedge HCLK);
        HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HSIZE = 3'd2; HADDR = 12'h020; HWDATA = 0;
        @(negedge HCLK);
        HRESET = 1; HSEL = 0; HTRANS = 2'b00; HWDATA = 32'hDEADBEEF;
        #1;
        check("rst_mid_en", {ahb_sram_en, ahb_sram_we, ahb_sram_enb, ahb_sram_wb}, 0);
        @(negedge HCLK);
        HRESET = 0;
        #1;
        check("rst_mid_ready", HREADYOUT, 1);
        push(0, 12'h020, 3'd2, 32'h0, 0);
        run_queue();

        // Random traffic inside the initialised region.
        for (int n = 0; n < 250; n++) begin
            x.idle  = ($urandom_range(0, 7) == 0);
            x.wr    = 1'($urandom_range(0, 1));
            x.size  = 3'($urandom_range(0, 2));
            x.addr  = 12'($urandom_range(0, 63));
            x.wdata = $urandom;
`ifdef AHB_SSRAM_ERR_EN
            if (x.size == 3'd1) x.addr[0] = 1'b0;
            if (x.size == 3'd2) x.addr[1:0] = 2'b00;
`else
            if ($urandom_range(0, 7) == 0) x.size = 3'($urandom_range(3, 7));
`endif
            xq.push_back(x);
        end
        run_queue();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
